naxis_step_gen: RTL and testbench
=================================

Name: naxis_step_gen

Overview:
- Parametrised N-axis step/dir pulse generator and the successor to the fixed six-axis controller.
- Hangs off the MicroBlaze MCS IO bus in the clk10 domain and drives stepper drivers.
- Each axis moves from its current position to a software-written target at a programmable step period, with alarm-driven stop and a global busy mask.
- Adds over the six-axis block: parametrised axis count/widths, position readback/preload, per-axis abort and latched alarms.

Parameters:
- NUM_AXES, 6, number of axes (1..15).
- POS_W, 32, signed position/target width.
- PER_W, 16, step period counter width (clk cycles).
- PULSE_W, 20, step high time in clk cycles.
- DIR_SETUP, 10, cycles between dir change and step rising edge.
- BASE_ADDR, 32'hC000_0000, IO base; decode plbAddr[31:12].

Ports:
- clk  in  1  system clock (clk10).
- rst  in  1  synchronous active-high reset.
- plbEn  in  1  IO address strobe.
- plbRd  in  1  read strobe.
- plbWr  in  1  write strobe.
- plbBE  in  4  byte enables.
- plbAddr  in  32  byte address.
- plbWrData  in  32  write data.
- plbReady  out  1  transfer complete.
- plbRdData  out  32  read data.
- mAlarm  in  NUM_AXES  driver alarm, async, active high.
- mDir  out  NUM_AXES  direction, 1 = positive.
- mStep  out  NUM_AXES  step pulse, active high.
- busy  out  NUM_AXES  axis moving.

Behaviour:
- Reset: plbReady=0, plbRdData=0, mDir=0, mStep=0, busy=0. All positions, targets and alarm latches are 0; all periods are 0 (halted); all FSMs in IDLE.
- Bus handshake:
  - Hit = plbEn & plbAddr[31:12]==BASE_ADDR[31:12]. Axis index = plbAddr[7:4]; register = plbAddr[3:2].
  - plbReady pulses exactly 1 cycle, one cycle after a hit; plbRdData is valid only in that cycle and 0 otherwise.
  - A miss never asserts plbReady.
  - Writes honour plbBE per byte.
  - Axis index >= NUM_AXES (except 15) reads 0; writes are ignored but still acked.
- Per-axis registers:
  - reg0 TARGET (RW, signed).
  - reg1 POSITION (RO while busy; a write when IDLE preloads both position and target).
  - reg2 PERIOD (RW, low PER_W bits).
  - reg3 CTRL/STATUS. Read: bit0 busy, bit1 alarm latched, bit2 dir. Write: bit0=1 aborts (target:=position at next IDLE); bit1=1 clears the alarm latch.
- Global register (axis 15, reg0, RO): bits[NUM_AXES-1:0] busy mask.
- Alarm sync: 2-FF synchroniser per axis. A synchronised rising edge sets the latch. While the latch is set, no new steps start; a pulse in progress completes its full PULSE_W.
- Axis FSM:
  - IDLE: if position!=target, period!=0 and no alarm, set dir=(target>position) signed compare. If dir changed -> SETUP; else -> PULSE.
  - SETUP: DIR_SETUP cycles -> PULSE.
  - PULSE: mStep=1 for PULSE_W cycles. Position is incremented or decremented by 1 on the first PULSE cycle. Then -> GAP.
  - GAP: mStep=0. Count to eff_period - PULSE_W, where eff_period = max(period, 2*PULSE_W). Then -> IDLE.
  - busy=1 in every state except IDLE. IDLE->PULSE re-evaluation costs no extra cycle.
- Abort or alarm mid-move:
  - The FSM finishes the current PULSE/GAP and then holds IDLE.
  - An alarm forces target:=position on entry to IDLE.
  - Rewriting TARGET mid-move takes effect at the next IDLE; dir reverses through SETUP.
- Period written as 0 mid-move: the axis halts at the next IDLE.
- Position wraps modulo 2^POS_W; no saturation.
- Simultaneous bus write to POSITION while busy: ignored.
- Simultaneous TARGET write and abort in one word: abort wins.

Decomposition:
- Package naxis_pkg holds:
  - register offsets (REG_TARGET=0, REG_POSITION=1, REG_PERIOD=2, REG_CTRL=3, AXIS_GLOBAL=15);
  - CTRL bit indices;
  - FSM state enum (IDLE, SETUP, PULSE, GAP).
- One sub-module, axis_step_fsm: a single axis with its alarm sync, position/target/period registers and FSM. It is instantiated NUM_AXES times in a generate loop.
- The top handles bus decode and read muxing.

Test Plan:
- Reset, then read axis0 reg3 and global -> 0. After an access, plbReady is high exactly 1 cycle later, for 1 cycle.
- Axis2: PERIOD=100, TARGET=5 -> 5 mStep[2] pulses, each 20 cycles high, 100 cycles apart. mDir[2]=1 at least 10 cycles before the first rise. POSITION reads 5; busy[2] falls.
- Axis0: TARGET=-3 from 0 with PERIOD=10 -> period is clamped to 40; mDir=0; POSITION=-3 (0xFFFFFFFD).
- Assert mAlarm[1] mid-pulse during a 10-step move -> that pulse still lasts 20 cycles and no further steps occur. STATUS bit1=1; TARGET reads back equal to POSITION. A write of CTRL=2 clears the latch.
- Change TARGET from +10 to 0 after 4 steps -> dir flips after SETUP, then 4 reverse steps, ending at POSITION 0.
- Write POSITION=1000 while IDLE -> POSITION=TARGET=1000 and no steps. The same write while busy -> ignored.

Source files
------------

// File: rtl/naxis_pkg.sv
// naxis_pkg: register map, control bits, axis state encoding and byte-lane merge helper
package naxis_pkg;
  localparam logic [1:0] REG_TARGET = 2'd0;
  localparam logic [1:0] REG_POSITION = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;
  localparam logic [3:0] AXIS_GLOBAL = 4'd15;
  localparam int CTRL_BUSY = 0;
  localparam int CTRL_ALARM = 1;
  localparam int CTRL_DIR = 2;
  localparam int CTRL_ABORT = 0;
  localparam int CTRL_CLR = 1;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} axis_state_t;
  function automatic logic [31:0] be_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/axis_step_fsm.sv
// axis_step_fsm: one axis with alarm sync, position/target/period registers and step/dir sequencer
module axis_step_fsm
  import naxis_pkg::*;
#(
  parameter int POS_W = 32,
  parameter int PER_W = 16,
  parameter int PULSE_W = 20,
  parameter int DIR_SETUP = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        alarm,
  output logic [31:0] rd_data,
  output logic        dir,
  output logic        step,
  output logic        busy
);
  axis_state_t state, state_nx;
  logic [31:0] cnt, eff, gap_len, status, merged;
  logic signed [POS_W-1:0] position, target;
  logic [PER_W-1:0] period;
  logic [2:0] a_sync;
  logic alarm_lat, abort_pend, dir_nx, at_idle, go, pos_wr, ctrl_wr;
  always_comb begin
    busy = state != IDLE;
    step = state == PULSE;
    eff = 32'(period) > 32'(2 * PULSE_W) ? 32'(period) : 32'(2 * PULSE_W);
    gap_len = eff - 32'(PULSE_W);
    pos_wr = wr && reg_sel == REG_POSITION && state == IDLE;
    ctrl_wr = wr && reg_sel == REG_CTRL && wr_be[0];
    at_idle = state == IDLE || (state == GAP && cnt >= gap_len - 32'd1);
    go = at_idle && position != target && period != '0 && !alarm_lat && !abort_pend && !pos_wr;
    dir_nx = target > position;
    state_nx = go ? (dir_nx != dir ? SETUP : PULSE)
             : at_idle ? IDLE
             : (state == SETUP && cnt == 32'(DIR_SETUP - 1)) ? PULSE
             : (state == PULSE && cnt == 32'(PULSE_W - 1)) ? GAP : state;
    status = '0;
    status[CTRL_BUSY] = busy;
    status[CTRL_ALARM] = alarm_lat;
    status[CTRL_DIR] = dir;
    rd_data = reg_sel == REG_TARGET ? 32'(target)
            : reg_sel == REG_POSITION ? 32'(position)
            : reg_sel == REG_PERIOD ? 32'(period) : status;
    merged = be_merge(rd_data, wr_data, wr_be);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      position <= '0;
      target <= '0;
      period <= '0;
      a_sync <= '0;
      alarm_lat <= 1'b0;
      abort_pend <= 1'b0;
      dir <= 1'b0;
    end else begin
      a_sync <= {a_sync[1:0], alarm};
      state <= state_nx;
      cnt <= state_nx != state ? '0 : cnt + 32'd1;
      if (go) dir <= dir_nx;
      if (state == PULSE && cnt == '0) position <= dir ? position + POS_W'(1) : position - POS_W'(1);
      if (wr && reg_sel == REG_TARGET) target <= POS_W'(merged);
      if (wr && reg_sel == REG_PERIOD) period <= PER_W'(merged);
      if (pos_wr) begin
        position <= POS_W'(merged);
        target <= POS_W'(merged);
      end
      if (at_idle && abort_pend) begin
        target <= position;
        abort_pend <= 1'b0;
      end
      if (ctrl_wr && wr_data[CTRL_CLR]) alarm_lat <= 1'b0;
      if (ctrl_wr && wr_data[CTRL_ABORT]) abort_pend <= 1'b1;
      if (a_sync[1] && !a_sync[2]) begin
        alarm_lat <= 1'b1;
        abort_pend <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/naxis_step_gen.sv
// naxis_step_gen: N-axis step/dir generator with IO-bus register decode and read muxing
module naxis_step_gen
  import naxis_pkg::*;
#(
  parameter int NUM_AXES = 6,
  parameter int POS_W = 32,
  parameter int PER_W = 16,
  parameter int PULSE_W = 20,
  parameter int DIR_SETUP = 10,
  parameter logic [31:0] BASE_ADDR = 32'hC000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                plbEn,
  input  logic                plbRd,
  input  logic                plbWr,
  input  logic [3:0]          plbBE,
  input  logic [31:0]         plbAddr,
  input  logic [31:0]         plbWrData,
  output logic                plbReady,
  output logic [31:0]         plbRdData,
  input  logic [NUM_AXES-1:0] mAlarm,
  output logic [NUM_AXES-1:0] mDir,
  output logic [NUM_AXES-1:0] mStep,
  output logic [NUM_AXES-1:0] busy
);
  logic hit, unused_addr;
  logic [3:0] axis;
  logic [1:0] reg_sel;
  logic [31:0] rd_mux;
  logic [31:0] ax_rd [16];
  assign hit = plbEn && plbAddr[31:12] == BASE_ADDR[31:12];
  assign axis = plbAddr[7:4];
  assign reg_sel = plbAddr[3:2];
  assign unused_addr = ^{plbAddr[11:8], plbAddr[1:0]};
  always_comb rd_mux = axis == AXIS_GLOBAL ? (reg_sel == REG_TARGET ? 32'(busy) : '0) : ax_rd[axis];
  for (genvar i = 0; i < 16; i++) begin : g_ax
    if (i < NUM_AXES) begin : g_on
      axis_step_fsm #(
        .POS_W(POS_W),
        .PER_W(PER_W),
        .PULSE_W(PULSE_W),
        .DIR_SETUP(DIR_SETUP)
      ) u_axis (
        .clk(clk),
        .rst(rst),
        .wr(hit && plbWr && axis == 4'(i)),
        .reg_sel(reg_sel),
        .wr_data(plbWrData),
        .wr_be(plbBE),
        .alarm(mAlarm[i]),
        .rd_data(ax_rd[i]),
        .dir(mDir[i]),
        .step(mStep[i]),
        .busy(busy[i])
      );
    end else begin : g_off
      assign ax_rd[i] = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      plbReady <= 1'b0;
      plbRdData <= '0;
    end else begin
      plbReady <= hit;
      plbRdData <= hit && plbRd ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_naxis_step_gen.sv
// tb_naxis_step_gen: scoreboard bench for bus reads/acks plus step timing checks on axes 0..2
module tb_naxis_step_gen;
  localparam int NA = 6;
  localparam logic [31:0] BASE = 32'hC000_0000;
  logic clk = 1'b0, rst = 1'b1;
  logic plbEn, plbRd, plbWr, plbReady;
  logic [3:0] plbBE;
  logic [31:0] plbAddr, plbWrData, plbRdData;
  logic [NA-1:0] mAlarm, mDir, mStep, busy;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] exp_q [$];
  string tag_q [$];
  int nrise [3] = '{default: 0};
  int rise_at [3][32];
  int width [3][32];
  int setup_at [3][32];
  int hi_start [3] = '{default: 0};
  int dir_chg [3] = '{default: 0};
  logic [2:0] step_q = '0, dir_q = '0;

  always #5 clk = ~clk;

  naxis_step_gen #(.NUM_AXES(NA)) dut (
    .clk(clk), .rst(rst), .plbEn(plbEn), .plbRd(plbRd), .plbWr(plbWr), .plbBE(plbBE),
    .plbAddr(plbAddr), .plbWrData(plbWrData), .plbReady(plbReady), .plbRdData(plbRdData),
    .mAlarm(mAlarm), .mDir(mDir), .mStep(mStep), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      if (mDir[a] != dir_q[a]) dir_chg[a] = cyc;
      if (mStep[a] && !step_q[a]) begin
        if (nrise[a] < 32) begin
          rise_at[a][nrise[a]] = cyc;
          setup_at[a][nrise[a]] = cyc - dir_chg[a];
        end
        hi_start[a] = cyc;
        nrise[a]++;
      end
      if (!mStep[a] && step_q[a] && nrise[a] <= 32) width[a][nrise[a]-1] = cyc - hi_start[a];
      step_q[a] = mStep[a];
      dir_q[a] = mDir[a];
    end
  end

  initial forever begin
    @(negedge clk);
    if (plbReady) begin
      if (exp_q.size() == 0) check("spurious ack", 32'd1, 32'd0);
      else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string t = tag_q.pop_front();
        check(t, plbRdData, e);
      end
    end
  end

  task automatic bus(input logic wr, input int ax, input int rg, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] exp_rd, input string tag);
    exp_q.push_back(wr ? 32'd0 : exp_rd);
    tag_q.push_back(tag);
    @(negedge clk);
    plbEn = 1'b1;
    plbRd = !wr;
    plbWr = wr;
    plbAddr = BASE | (32'(ax) << 4) | (32'(rg) << 2);
    plbWrData = d;
    plbBE = be;
    @(negedge clk);
    plbEn = 1'b0;
    plbRd = 1'b0;
    plbWr = 1'b0;
    check({tag, " rdy"}, {31'd0, plbReady}, 32'd1);
    @(negedge clk);
    check({tag, " rdy drop"}, {31'd0, plbReady}, 32'd0);
  endtask

  task automatic bus_rd(input int ax, input int rg, input logic [31:0] exp_rd, input string tag);
    bus(1'b0, ax, rg, 32'd0, 4'h0, exp_rd, tag);
  endtask

  task automatic bus_wr(input int ax, input int rg, input logic [31:0] d, input logic [3:0] be);
    bus(1'b1, ax, rg, d, be, 32'd0, "wr ack data");
  endtask

  task automatic wait_idle(input int ax, input string tag);
    int k = 0;
    repeat (4) @(negedge clk);
    while (busy[ax] && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, busy[ax]}, 32'd0);
  endtask

  task automatic wait_rise(input int ax, input int n, input string tag);
    int k = 0;
    while (nrise[ax] < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, nrise[ax] >= n}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  initial begin
    plbEn = 1'b0;
    plbRd = 1'b0;
    plbWr = 1'b0;
    plbBE = 4'h0;
    plbAddr = '0;
    plbWrData = '0;
    mAlarm = '0;
    repeat (3) @(negedge clk);
    check("rst ready", {31'd0, plbReady}, 32'd0);
    check("rst rddata", plbRdData, 32'd0);
    check("rst dir", 32'(mDir), 32'd0);
    check("rst step", 32'(mStep), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_rd(0, 3, 32'd0, "rst ax0 status");
    bus_rd(15, 0, 32'd0, "rst global");
    @(negedge clk);
    plbEn = 1'b1;
    plbRd = 1'b1;
    plbAddr = 32'hC000_1030;
    @(negedge clk);
    plbEn = 1'b0;
    plbRd = 1'b0;
    check("miss rdy", {31'd0, plbReady}, 32'd0);
    @(negedge clk);
    check("miss rdy late", {31'd0, plbReady}, 32'd0);

    bus_wr(2, 2, 32'd100, 4'hF);
    bus_wr(2, 0, 32'd5, 4'hF);
    wait_idle(2, "ax2 move done");
    check("ax2 steps", 32'(nrise[2]), 32'd5);
    for (int i = 0; i < 5; i++) check("ax2 width", 32'(width[2][i]), 32'd20);
    for (int i = 0; i < 4; i++) check("ax2 spacing", 32'(rise_at[2][i+1] - rise_at[2][i]), 32'd100);
    check("ax2 dir setup", {31'd0, setup_at[2][0] >= 10}, 32'd1);
    check("ax2 dir", {31'd0, mDir[2]}, 32'd1);
    bus_rd(2, 1, 32'd5, "ax2 position");
    bus_rd(2, 3, 32'h4, "ax2 status");

    bus_wr(0, 2, 32'hFFFF_000A, 4'b0001);
    bus_rd(0, 2, 32'h0000_000A, "ax0 period be");
    bus_wr(0, 0, 32'hFFFF_FFFD, 4'hF);
    wait_idle(0, "ax0 move done");
    check("ax0 steps", 32'(nrise[0]), 32'd3);
    for (int i = 0; i < 2; i++) check("ax0 clamped spacing", 32'(rise_at[0][i+1] - rise_at[0][i]), 32'd40);
    check("ax0 dir", {31'd0, mDir[0]}, 32'd0);
    bus_rd(0, 1, 32'hFFFF_FFFD, "ax0 position");

    bus_wr(1, 2, 32'd100, 4'hF);
    bus_wr(1, 0, 32'd10, 4'hF);
    wait_rise(1, 3, "ax1 third step");
    repeat (5) @(negedge clk);
    mAlarm[1] = 1'b1;
    wait_idle(1, "ax1 alarm stop");
    check("ax1 steps", 32'(nrise[1]), 32'd3);
    check("ax1 alarm pulse width", 32'(width[1][2]), 32'd20);
    bus_rd(1, 3, 32'h6, "ax1 alarm status");
    bus_rd(1, 1, 32'd3, "ax1 position");
    bus_rd(1, 0, 32'd3, "ax1 target=pos");
    mAlarm[1] = 1'b0;
    bus_wr(1, 3, 32'd2, 4'hF);
    bus_rd(1, 3, 32'h4, "ax1 alarm cleared");
    repeat (50) @(negedge clk);
    check("ax1 no restart", 32'(nrise[1]), 32'd3);

    bus_wr(0, 0, 32'd100, 4'hF);
    wait_rise(0, 5, "ax0 second step");
    bus_wr(0, 3, 32'd1, 4'hF);
    wait_idle(0, "ax0 abort stop");
    check("ax0 abort steps", 32'(nrise[0]), 32'd5);
    bus_rd(0, 1, 32'hFFFF_FFFF, "ax0 abort position");
    bus_rd(0, 0, 32'hFFFF_FFFF, "ax0 abort target");

    bus_wr(2, 1, 32'd0, 4'hF);
    bus_rd(2, 0, 32'd0, "ax2 preload target");
    bus_wr(2, 0, 32'd10, 4'hF);
    wait_rise(2, 9, "ax2 fourth fwd step");
    bus_wr(2, 0, 32'd0, 4'hF);
    wait_idle(2, "ax2 reverse done");
    check("ax2 total steps", 32'(nrise[2]), 32'd13);
    check("ax2 reverse setup", {31'd0, setup_at[2][9] >= 10}, 32'd1);
    check("ax2 reverse dir", {31'd0, mDir[2]}, 32'd0);
    bus_rd(2, 1, 32'd0, "ax2 back home");

    bus_wr(2, 1, 32'd1000, 4'hF);
    bus_rd(2, 1, 32'd1000, "ax2 preload pos");
    bus_rd(2, 0, 32'd1000, "ax2 preload tgt");
    repeat (30) @(negedge clk);
    check("ax2 preload no steps", 32'(nrise[2]), 32'd13);
    check("ax2 preload idle", {31'd0, busy[2]}, 32'd0);
    bus_wr(2, 0, 32'd1003, 4'hF);
    check("ax2 busy", {31'd0, busy[2]}, 32'd1);
    bus_rd(15, 0, 32'h4, "global busy mask");
    bus_wr(2, 1, 32'd7, 4'hF);
    wait_idle(2, "ax2 final move");
    bus_rd(2, 1, 32'd1003, "ax2 busy pos write ignored");
    check("ax2 final steps", 32'(nrise[2]), 32'd16);

    bus_wr(9, 0, 32'd123, 4'hF);
    bus_rd(9, 0, 32'd0, "ax9 out of range");
    bus_rd(15, 1, 32'd0, "global reg1");
    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
